// File: rtl/audio_mix_pkg.sv
// -----------------------------------------------------------------------------
// audio_mix_pkg
// Shared types and helpers for the audio channel mixer:
//   mix_state_t  - pass sequencer states
//   mix_mode_t   - crossfeed amount selector
//   calc_aw      - accumulator width for given sample/gain width and channels
//   unity_gain   - gain code meaning 1.0 for an unsigned Q1.(GW-1) gain
//   sat_f        - clamp a wide signed value into an ow-bit signed range
// -----------------------------------------------------------------------------
package audio_mix_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACCUM = 3'd1,
    SCALE = 3'd2,
    XFEED = 3'd3,
    SAT   = 3'd4
  } mix_state_t;

  typedef enum logic [1:0] {
    MIX_NONE = 2'd0,
    MIX_12   = 2'd1,
    MIX_25   = 2'd2,
    MIX_MONO = 2'd3
  } mix_mode_t;

  // One guard bit on top of the worst-case sum of NCH full-scale products.
  function automatic int calc_aw(input int dw, input int gw, input int nch);
    return dw + gw + $clog2(nch) + 1;
  endfunction

  function automatic int unity_gain(input int gw);
    return 1 << (gw - 1);
  endfunction

  // Result is kept 64 bits wide (sign-extended) so callers can compare it
  // against the unclamped input to detect clipping.
  function automatic logic signed [63:0] sat_f(input logic signed [63:0] x,
                                               input int ow);
    logic signed [63:0] hi_v;
    logic signed [63:0] lo_v;
    hi_v = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo_v = -(64'sd1 <<< (ow - 1));
    if (x > hi_v) begin
      return hi_v;
    end else if (x < lo_v) begin
      return lo_v;
    end else begin
      return x;
    end
  endfunction

endpackage

// File: rtl/audio_saturate.sv
// -----------------------------------------------------------------------------
// audio_saturate
// Combinational clamp of a signed IW-bit value into a signed OW-bit range.
// Ports:
//   in_v   in  IW  signed value to clamp (IW <= 64)
//   out_v  out OW  clamped value
//   clip   out 1   high when in_v was outside the OW-bit range
// -----------------------------------------------------------------------------
module audio_saturate
  import audio_mix_pkg::*;
#(
  parameter int IW = 27,
  parameter int OW = 16
) (
  input  logic signed [IW-1:0] in_v,
  output logic signed [OW-1:0] out_v,
  output logic                 clip
);

  logic signed [63:0] ext_s;
  logic signed [63:0] sat_s;

  // Sign-extend, clamp and flag any change made by the clamp.
  always_comb begin
    ext_s = 64'(in_v);
    sat_s = sat_f(ext_s, OW);
    out_v = sat_s[OW-1:0];
    clip  = (sat_s != ext_s);
  end

endmodule

// File: rtl/audio_channel_mixer.sv
// -----------------------------------------------------------------------------
// audio_channel_mixer
// N-channel stereo mixer. A sample_tick snapshots all inputs, then one MAC per
// channel per cycle builds the L/R sums, followed by gain/attenuation scaling,
// stereo crossfeed and saturation. One result per NCH+4 cycles.
//
// Ports:
//   clk_audio   in   audio clock (rising edge)
//   reset       in   synchronous active-high reset
//   sample_tick in   start a mix pass (ignored and flagged if busy)
//   is_signed   in   1: two's complement inputs, 0: offset-binary
//   ch_l/ch_r   in   NCH*DW packed channel samples
//   ch_gain     in   NCH*GW packed unsigned Q1.(GW-1) gains
//   vol_att     in   master attenuation shift 0..15
//   mix         in   crossfeed 0 none, 1 12.5%, 2 25%, 3 mono
//   mute        in   master mute
//   out_l/out_r out  signed result, held between strobes
//   out_valid   out  one-cycle strobe with each new result
//   busy        out  pass in progress
//   clip        out  saturation in the current result
//   overrun     out  sticky: tick arrived while not idle
//
// Build option: AUDIO_MIXER_SOFT_MUTE_EN replaces the hard mute with a
// ramped master gain (0..128, step 8 per result).
// -----------------------------------------------------------------------------
module audio_channel_mixer
  import audio_mix_pkg::*;
#(
  parameter int NCH = 4,
  parameter int DW  = 16,
  parameter int GW  = 8
) (
  input  logic              clk_audio,
  input  logic              reset,
  input  logic              sample_tick,
  input  logic              is_signed,
  input  logic [NCH*DW-1:0] ch_l,
  input  logic [NCH*DW-1:0] ch_r,
  input  logic [NCH*GW-1:0] ch_gain,
  input  logic [3:0]        vol_att,
  input  logic [1:0]        mix,
  input  logic              mute,
  output logic [DW-1:0]     out_l,
  output logic [DW-1:0]     out_r,
  output logic              out_valid,
  output logic              busy,
  output logic              clip,
  output logic              overrun
);

  localparam int AW   = calc_aw(DW, GW, NCH);
  localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
`ifdef AUDIO_MIXER_SOFT_MUTE_EN
  localparam int SIW  = AW + 9;
`else
  localparam int SIW  = AW;
`endif

  mix_state_t state_r;
  mix_state_t state_s;

  logic signed [DW-1:0] snap_l_r [NCH];
  logic signed [DW-1:0] snap_r_r [NCH];
  logic [GW-1:0]        snap_g_r [NCH];
  logic [3:0]           vol_r;
  mix_mode_t            mode_r;
  logic                 mute_r;
  logic [IDXW-1:0]      idx_r;
  logic signed [AW-1:0] acc_l_r;
  logic signed [AW-1:0] acc_r_r;

  logic [DW-1:0] out_l_r;
  logic [DW-1:0] out_r_r;
  logic          out_valid_r;
  logic          busy_r;
  logic          clip_r;
  logic          overrun_r;

  logic signed [AW-1:0]  gain_s;
  logic signed [AW-1:0]  mac_l_s;
  logic signed [AW-1:0]  mac_r_s;
  logic signed [AW-1:0]  scl_l_s;
  logic signed [AW-1:0]  scl_r_s;
  logic [1:0]            k_s;
  logic signed [AW-1:0]  xf_l_s;
  logic signed [AW-1:0]  xf_r_s;
  logic signed [SIW-1:0] sat_in_l_s;
  logic signed [SIW-1:0] sat_in_r_s;
  logic signed [DW-1:0]  sat_l_s;
  logic signed [DW-1:0]  sat_r_s;
  logic                  clip_l_s;
  logic                  clip_r_s;

`ifdef AUDIO_MIXER_SOFT_MUTE_EN
  logic [7:0] mg_r;
`endif

  // State register.
  always_ff @(posedge clk_audio) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: one ACCUM cycle per channel, then three fixed stages.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (sample_tick) begin
          state_s = ACCUM;
        end else begin
          state_s = IDLE;
        end
      end
      ACCUM: begin
        if (idx_r == IDXW'(NCH - 1)) begin
          state_s = SCALE;
        end else begin
          state_s = ACCUM;
        end
      end
      SCALE:   state_s = XFEED;
      XFEED:   state_s = SAT;
      SAT:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Datapath arithmetic for the current stage.
  always_comb begin
    // Gain is unsigned; a zero MSB makes the product signed-by-unsigned.
    gain_s  = AW'($signed({1'b0, snap_g_r[idx_r]}));
    mac_l_s = acc_l_r + AW'(snap_l_r[idx_r]) * gain_s;
    mac_r_s = acc_r_r + AW'(snap_r_r[idx_r]) * gain_s;

    scl_l_s = (acc_l_r >>> (GW - 1)) >>> vol_r;
    scl_r_s = (acc_r_r >>> (GW - 1)) >>> vol_r;

    case (mode_r)
      MIX_NONE: k_s = 2'd0;
      MIX_12:   k_s = 2'd3;
      MIX_25:   k_s = 2'd2;
      MIX_MONO: k_s = 2'd1;
      default:  k_s = 2'd0;
    endcase

    if (k_s == 2'd0) begin
      xf_l_s = acc_l_r;
      xf_r_s = acc_r_r;
    end else begin
      xf_l_s = acc_l_r - (acc_l_r >>> k_s) + (acc_r_r >>> k_s);
      xf_r_s = acc_r_r - (acc_r_r >>> k_s) + (acc_l_r >>> k_s);
    end

`ifdef AUDIO_MIXER_SOFT_MUTE_EN
    sat_in_l_s = (SIW'(acc_l_r) * SIW'($signed({1'b0, mg_r}))) >>> 7;
    sat_in_r_s = (SIW'(acc_r_r) * SIW'($signed({1'b0, mg_r}))) >>> 7;
`else
    sat_in_l_s = acc_l_r;
    sat_in_r_s = acc_r_r;
`endif
  end

  audio_saturate #(.IW(SIW), .OW(DW)) u_sat_l (
    .in_v  (sat_in_l_s),
    .out_v (sat_l_s),
    .clip  (clip_l_s)
  );

  audio_saturate #(.IW(SIW), .OW(DW)) u_sat_r (
    .in_v  (sat_in_r_s),
    .out_v (sat_r_s),
    .clip  (clip_r_s)
  );

  // Snapshot, accumulation, output registers and status flags.
  always_ff @(posedge clk_audio) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        snap_l_r[i] <= '0;
        snap_r_r[i] <= '0;
        snap_g_r[i] <= '0;
      end
      vol_r       <= 4'd0;
      mode_r      <= MIX_NONE;
      mute_r      <= 1'b0;
      idx_r       <= '0;
      acc_l_r     <= '0;
      acc_r_r     <= '0;
      out_l_r     <= '0;
      out_r_r     <= '0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      clip_r      <= 1'b0;
      overrun_r   <= 1'b0;
`ifdef AUDIO_MIXER_SOFT_MUTE_EN
      mg_r        <= 8'd128;
`endif
    end else begin
      out_valid_r <= 1'b0;
      busy_r      <= (state_s != IDLE);
      // A tick arriving in any non-idle state (including SAT) is dropped.
      if (sample_tick && (state_r != IDLE)) begin
        overrun_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (sample_tick) begin
            // Offset-binary to two's complement is an MSB flip.
            for (int i = 0; i < NCH; i++) begin
              snap_l_r[i] <= ch_l[i*DW +: DW] ^ {~is_signed, {(DW-1){1'b0}}};
              snap_r_r[i] <= ch_r[i*DW +: DW] ^ {~is_signed, {(DW-1){1'b0}}};
              snap_g_r[i] <= ch_gain[i*GW +: GW];
            end
            vol_r   <= vol_att;
            mode_r  <= mix_mode_t'(mix);
            mute_r  <= mute;
            idx_r   <= '0;
            acc_l_r <= '0;
            acc_r_r <= '0;
          end
        end
        ACCUM: begin
          acc_l_r <= mac_l_s;
          acc_r_r <= mac_r_s;
          idx_r   <= idx_r + IDXW'(1'b1);
        end
        SCALE: begin
          acc_l_r <= scl_l_s;
          acc_r_r <= scl_r_s;
        end
        XFEED: begin
          acc_l_r <= xf_l_s;
          acc_r_r <= xf_r_s;
        end
        SAT: begin
          out_valid_r <= 1'b1;
`ifdef AUDIO_MIXER_SOFT_MUTE_EN
          out_l_r <= sat_l_s;
          out_r_r <= sat_r_s;
          clip_r  <= clip_l_s | clip_r_s;
          // Ramp the master gain one step per result toward the mute target.
          if (mute_r) begin
            mg_r <= (mg_r >= 8'd8) ? (mg_r - 8'd8) : 8'd0;
          end else begin
            mg_r <= (mg_r <= 8'd120) ? (mg_r + 8'd8) : 8'd128;
          end
`else
          if (mute_r) begin
            out_l_r <= '0;
            out_r_r <= '0;
            clip_r  <= 1'b0;
          end else begin
            out_l_r <= sat_l_s;
            out_r_r <= sat_r_s;
            clip_r  <= clip_l_s | clip_r_s;
          end
`endif
        end
        default: begin
        end
      endcase
    end
  end

  assign out_l     = out_l_r;
  assign out_r     = out_r_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign clip      = clip_r;
  assign overrun   = overrun_r;

endmodule
